// File: rtl/mio_ram_loader_pkg.sv
// Shared constants and loader state encoding for the writable instruction store.
package mio_ram_loader_pkg;
  localparam int         AW       = 7;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/mio_ram_loader_ram.sv
// inst_ram_2r1w: 2**AW x 32 store, two asynchronous read ports, one synchronous write port.
module inst_ram_2r1w #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);
  // No reset: contents survive reset and aborted loads.
  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads see the pre-write contents during the write cycle.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/mio_ram_loader.sv
// Byte-stream boot loader in front of a writable 128x32 instruction store.
// Frame: HDR_BYTE, LEN (0 => full depth), LEN*4 data bytes MSB first, XOR checksum.
module mio_ram_loader
  import mio_ram_loader_pkg::*;
#(
  parameter int         AW       = mio_ram_loader_pkg::AW,
  parameter logic [7:0] HDR_BYTE = mio_ram_loader_pkg::HDR_BYTE,
  parameter int         TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_start,
  input  logic [31:0] a,
  output logic [31:0] inst,
  input  logic [31:0] rom_a,
  output logic [31:0] d_f_rom,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  word_count
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    phase;
  logic [23:0]   asm_q;
  logic [7:0]    xsum;
  logic [7:0]    len_q;
  logic [8:0]    n_words;
  logic          active, take, timed_out, last_word, we;

  assign active    = (state == S_HDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CSUM);
  // A restart pulse discards any byte arriving in the same cycle.
  assign take      = active && rx_valid && !load_start;
  assign timed_out = active && !rx_valid && (timer == TW'(TIMEOUT - 1));
  assign n_words   = (len_q == 8'd0) ? 9'(2**AW) : {1'b0, len_q};
  assign last_word = ({1'b0, word_count} + 9'd1) == n_words;
  assign we        = (state == S_DATA) && take && (phase == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = S_HDR;
    end else if (timed_out) begin
      state_nxt = S_ERR;
    end else if (take) begin
      case (state)
        S_HDR:   state_nxt = (rx_data == HDR_BYTE) ? S_LEN : S_ERR;
        S_LEN:   state_nxt = S_DATA;
        S_DATA:  if (phase == 2'd3 && last_word) state_nxt = S_CSUM;
        S_CSUM:  state_nxt = (rx_data == xsum) ? S_DONE : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      phase      <= '0;
      asm_q      <= '0;
      xsum       <= '0;
      len_q      <= '0;
      word_count <= '0;
    end else if (load_start) begin
      timer      <= '0;
      phase      <= '0;
      xsum       <= '0;
      word_count <= '0;
    end else if (active) begin
      timer <= rx_valid ? '0 : timer + TW'(1);
      if (take && state == S_LEN) len_q <= rx_data;
      if (take && state == S_DATA) begin
        asm_q <= {asm_q[15:0], rx_data};
        xsum  <= xsum ^ rx_data;
        phase <= phase + 2'd1;
        if (phase == 2'd3) word_count <= word_count + 8'd1;
      end
    end
  end

  inst_ram_2r1w #(.AW(AW)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (word_count[AW-1:0]),
    .wdata   ({asm_q, rx_data}),
    .raddr_a (a[AW+1:2]),
    .rdata_a (inst),
    .raddr_b (rom_a[AW+1:2]),
    .rdata_b (d_f_rom)
  );

  assign cpu_hold  = active || (state == S_ERR);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a[31:AW+2], a[1:0], rom_a[31:AW+2], rom_a[1:0]};
endmodule
